// File: rtl/sw_allocator.sv
// Switch allocator: per-output round-robin arbitration over the input-port
// controllers' direction requests, gated by downstream buffer credits.
// Grants, crossbar selects and error pulses are all registered, so a request
// sampled on one edge is answered during the following cycle.
module sw_allocator #(
  parameter int N_PORTS   = 5,
  parameter int DIR_W     = 3,
  parameter int BUF_DEPTH = 4,
  parameter int CNT_W     = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_PORTS*DIR_W-1:0] sw_req,
  input  logic [N_PORTS-1:0]       sw_req_valid,
  input  logic [N_PORTS-1:0]       credit_ret,
  output logic [N_PORTS-1:0]       sw_answer,
  output logic [N_PORTS*DIR_W-1:0] xbar_sel,
  output logic [N_PORTS-1:0]       xbar_valid,
  output logic [N_PORTS*CNT_W-1:0] credit_cnt,
  output logic                     req_err,
  output logic                     credit_err
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(BUF_DEPTH);
  localparam logic [DIR_W-1:0] PTR_INIT = DIR_W'(N_PORTS - 1);

  // Registered state and outputs
  logic [N_PORTS-1:0]       sw_answer_r;
  logic [N_PORTS-1:0]       xbar_valid_r;
  logic [N_PORTS*DIR_W-1:0] xbar_sel_r;
  logic [N_PORTS*CNT_W-1:0] credit_cnt_r;
  logic [DIR_W-1:0]         ptr_r [N_PORTS];
  logic                     req_err_r;
  logic                     credit_err_r;

  // Combinational next-state terms
  logic [N_PORTS-1:0]       req_s [N_PORTS];
  logic                     bad_dir_s;
  logic [DIR_W-1:0]         win_s [N_PORTS];
  logic [N_PORTS-1:0]       out_gnt_s;
  logic [N_PORTS-1:0]       in_gnt_s;
  logic [N_PORTS*DIR_W-1:0] xbar_sel_s;
  logic [N_PORTS*CNT_W-1:0] credit_cnt_s;
  logic                     credit_err_s;

  assign sw_answer  = sw_answer_r;
  assign xbar_valid = xbar_valid_r;
  assign xbar_sel   = xbar_sel_r;
  assign credit_cnt = credit_cnt_r;
  assign req_err    = req_err_r;
  assign credit_err = credit_err_r;

  // Decode each input's request into a per-output request vector; inputs
  // being answered this cycle are masked, out-of-range codes are flagged.
  always_comb begin
    bad_dir_s = 1'b0;
    for (int o = 0; o < N_PORTS; o++) begin
      req_s[o] = '0;
    end
    for (int i = 0; i < N_PORTS; i++) begin
      bad_dir_s = bad_dir_s |
                  (sw_req_valid[i] && (int'(sw_req[i*DIR_W +: DIR_W]) >= N_PORTS));
      for (int o = 0; o < N_PORTS; o++) begin
        req_s[o][i] = sw_req_valid[i] && !sw_answer_r[i] &&
                      (int'(sw_req[i*DIR_W +: DIR_W]) == o);
      end
    end
  end

  // Round-robin search per output starting just after the last winner;
  // an output with no credits never grants.
  always_comb begin : arb_p
    logic found_v;
    logic hit_v;
    int   idx_v;
    out_gnt_s = '0;
    found_v   = 1'b0;
    hit_v     = 1'b0;
    idx_v     = 0;
    for (int o = 0; o < N_PORTS; o++) begin
      win_s[o] = '0;
      found_v  = 1'b0;
      for (int k = 1; k <= N_PORTS; k++) begin
        idx_v    = (int'(ptr_r[o]) + k) % N_PORTS;
        hit_v    = req_s[o][idx_v] && !found_v;
        win_s[o] = hit_v ? DIR_W'(idx_v) : win_s[o];
        found_v  = found_v | hit_v;
      end
      out_gnt_s[o] = found_v && (credit_cnt_r[o*CNT_W +: CNT_W] != '0);
    end
  end

  // Fold per-output winners back into per-input grant pulses and crossbar selects.
  always_comb begin
    in_gnt_s   = '0;
    xbar_sel_s = '0;
    for (int o = 0; o < N_PORTS; o++) begin
      xbar_sel_s[o*DIR_W +: DIR_W] = out_gnt_s[o] ? win_s[o] : '0;
      for (int i = 0; i < N_PORTS; i++) begin
        in_gnt_s[i] = in_gnt_s[i] | (out_gnt_s[o] && (win_s[o] == DIR_W'(i)));
      end
    end
  end

  // Credit bookkeeping: a grant consumes one, a return adds one, both cancel;
  // a return to a full counter is dropped and reported.
  always_comb begin
    credit_cnt_s = credit_cnt_r;
    credit_err_s = 1'b0;
    for (int o = 0; o < N_PORTS; o++) begin
      case ({credit_ret[o], out_gnt_s[o]})
        2'b01: begin
          credit_cnt_s[o*CNT_W +: CNT_W] = credit_cnt_r[o*CNT_W +: CNT_W] - CNT_W'(1);
        end
        2'b10: begin
          if (credit_cnt_r[o*CNT_W +: CNT_W] == FULL_CNT) begin
            credit_cnt_s[o*CNT_W +: CNT_W] = FULL_CNT;
            credit_err_s                   = 1'b1;
          end else begin
            credit_cnt_s[o*CNT_W +: CNT_W] = credit_cnt_r[o*CNT_W +: CNT_W] + CNT_W'(1);
          end
        end
        default: begin
          credit_cnt_s[o*CNT_W +: CNT_W] = credit_cnt_r[o*CNT_W +: CNT_W];
        end
      endcase
    end
  end

  // State and output registers; reset drops pending grants and any credit
  // return sampled on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sw_answer_r  <= '0;
      xbar_valid_r <= '0;
      xbar_sel_r   <= '0;
      req_err_r    <= 1'b0;
      credit_err_r <= 1'b0;
      for (int o = 0; o < N_PORTS; o++) begin
        credit_cnt_r[o*CNT_W +: CNT_W] <= FULL_CNT;
        ptr_r[o]                       <= PTR_INIT;
      end
    end else begin
      sw_answer_r  <= in_gnt_s;
      xbar_valid_r <= out_gnt_s;
      xbar_sel_r   <= xbar_sel_s;
      credit_cnt_r <= credit_cnt_s;
      req_err_r    <= bad_dir_s;
      credit_err_r <= credit_err_s;
      for (int o = 0; o < N_PORTS; o++) begin
        if (out_gnt_s[o]) begin
          ptr_r[o] <= win_s[o];
        end else begin
          ptr_r[o] <= ptr_r[o];
        end
      end
    end
  end

endmodule
